// File: rtl/control_sequencer.sv
// Mini SRC hardwired control: T-step counter, opcode decoder, RUN/HALT status.
// Optional SINGLE_STEP_EN adds a step input and a PAUSE state between instructions.
module control_sequencer #(
  parameter int MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con,
  input  logic        stop,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic        run,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        ramWE,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowout,
  output logic        ZHighout,
  output logic        HIin,
  output logic        HIout,
  output logic        LOin,
  output logic        LOout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic        BAout,
  output logic        Cout,
  output logic        CONin,
  output logic        InPortout,
  output logic        OutPortIn
);

  typedef enum logic [1:0] {
    S_RESET, S_RUN, S_HALT, S_PAUSE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  t_q, t_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic        stop_q, stop_d;

  logic [4:0]  op;
  logic        unused_ir;
  logic        is_alu, is_imm, is_md, is_nn;
  logic        is_ld, is_ldi, is_st, is_br;
  logic        is_jr, is_jal, is_in, is_out;
  logic        is_mfhi, is_mflo, is_halt;
  logic [2:0]  last_t;
  logic        mem_step;

  assign op        = ir[31:27];
  assign unused_ir = ^ir[26:0];

  assign is_ld   = op == 5'd0;
  assign is_ldi  = op == 5'd1;
  assign is_st   = op == 5'd2;
  assign is_alu  = op >= 5'd3 && op <= 5'd11;
  assign is_imm  = op >= 5'd12 && op <= 5'd14;
  assign is_md   = op == 5'd15 || op == 5'd16;
  assign is_nn   = op == 5'd17 || op == 5'd18;
  assign is_br   = op == 5'd19;
  assign is_jr   = op == 5'd20;
  assign is_jal  = op == 5'd21;
  assign is_in   = op == 5'd22;
  assign is_out  = op == 5'd23;
  assign is_mfhi = op == 5'd24;
  assign is_mflo = op == 5'd25;
  assign is_halt = op == 5'd27;

  always_comb begin
    last_t = 3'd2;
    unique case (1'b1)
      is_ld, is_st:           last_t = 3'd7;
      is_md, is_br:           last_t = 3'd6;
      is_alu, is_imm, is_ldi: last_t = 3'd5;
      is_nn, is_jal:          last_t = 3'd4;
      is_jr, is_in, is_out,
      is_mfhi, is_mflo:       last_t = 3'd3;
      default:                last_t = 3'd2;
    endcase
  end

  // Memory read steps dwell until the wait counter reaches MEM_WAIT
  assign mem_step = (t_q == 3'd1) || (t_q == 3'd6 && is_ld);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_RESET;
      t_q     <= '0;
      wcnt_q  <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      wcnt_q  <= wcnt_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    wcnt_d  = wcnt_q;
    stop_d  = stop_q;
    unique case (state_q)
      S_RESET: begin
        state_d = S_RUN;
        t_d     = '0;
        wcnt_d  = '0;
        stop_d  = 1'b0;
      end
      S_RUN: begin
        stop_d = stop_q | stop;
        if (mem_step && wcnt_q != 2'(MEM_WAIT)) begin
          wcnt_d = wcnt_q + 2'd1;
        end else begin
          wcnt_d = '0;
          if (t_q == 3'd2 && is_halt) begin
            state_d = S_HALT;
          end else if (t_q == last_t) begin
            t_d    = '0;
            stop_d = 1'b0;
            if (stop_q || stop) state_d = S_HALT;
`ifdef SINGLE_STEP_EN
            else state_d = S_PAUSE;
`endif
          end else begin
            t_d = t_q + 3'd1;
          end
        end
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: if (step) state_d = S_RUN;
`endif
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  assign run = (state_q == S_RUN) || (state_q == S_PAUSE);

  always_comb begin
    {PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, ramWE} = '0;
    {Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, HIout} = '0;
    {LOin, LOout, Gra, Grb, Grc, R_in, R_out, BAout} = '0;
    {Cout, CONin, InPortout, OutPortIn} = '0;
    if (state_q == S_RUN) begin
      unique case (t_q)
        3'd0: {PCout, MARin, IncPC} = '1;
        3'd1: {Read, MDRin} = '1;
        3'd2: {MDRout, IRin} = '1;
        3'd3: begin
          unique case (1'b1)
            is_alu, is_imm: {Grb, R_out, Yin} = '1;
            is_md:   {Gra, R_out, Yin} = '1;
            is_nn:   {Grb, R_out, ZLowIn} = '1;
            is_ld, is_ldi, is_st: {Grb, BAout, R_out, Yin} = '1;
            is_br:   {Gra, R_out, CONin} = '1;
            is_jr:   {Gra, R_out, PCin} = '1;
            is_jal:  {PCout, Grb, R_in} = '1;
            is_in:   {InPortout, Gra, R_in} = '1;
            is_out:  {Gra, R_out, OutPortIn} = '1;
            is_mfhi: {HIout, Gra, R_in} = '1;
            is_mflo: {LOout, Gra, R_in} = '1;
            default: ;
          endcase
        end
        3'd4: begin
          unique case (1'b1)
            is_alu:  {Grc, R_out, ZLowIn} = '1;
            is_imm, is_ld, is_ldi, is_st: {Cout, ZLowIn} = '1;
            is_md:   {Grb, R_out, ZLowIn, ZHighIn} = '1;
            is_nn:   {ZLowout, Gra, R_in} = '1;
            is_br:   {PCout, Yin} = '1;
            is_jal:  {Gra, R_out, PCin} = '1;
            default: ;
          endcase
        end
        3'd5: begin
          unique case (1'b1)
            is_alu, is_imm, is_ldi: {ZLowout, Gra, R_in} = '1;
            is_md:        {ZLowout, LOin} = '1;
            is_ld, is_st: {ZLowout, MARin} = '1;
            is_br:        {Cout, ZLowIn} = '1;
            default: ;
          endcase
        end
        3'd6: begin
          unique case (1'b1)
            is_md:   {ZHighout, HIin} = '1;
            is_ld:   {Read, MDRin} = '1;
            is_st:   {Gra, R_out, MDRin} = '1;
            is_br:   if (con) {ZLowout, PCin} = '1;
            default: ;
          endcase
        end
        default: begin
          if (is_ld) {MDRout, Gra, R_in} = '1;
          else if (is_st) ramWE = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instruction scenarios,
// per-cycle expected strobe vectors queued and checked by a negedge monitor.
module tb_control_sequencer;

  localparam int MW = 2;

  typedef logic [28:0] vec_t;
  typedef struct {
    vec_t  v;
    string tag;
  } exp_t;

  localparam vec_t B_RUN   = vec_t'(1) << 28;
  localparam vec_t B_PCOUT = vec_t'(1) << 27;
  localparam vec_t B_PCIN  = vec_t'(1) << 26;
  localparam vec_t B_INCPC = vec_t'(1) << 25;
  localparam vec_t B_IRIN  = vec_t'(1) << 24;
  localparam vec_t B_MARIN = vec_t'(1) << 23;
  localparam vec_t B_MDRIN = vec_t'(1) << 22;
  localparam vec_t B_MDROUT= vec_t'(1) << 21;
  localparam vec_t B_READ  = vec_t'(1) << 20;
  localparam vec_t B_RAMWE = vec_t'(1) << 19;
  localparam vec_t B_YIN   = vec_t'(1) << 18;
  localparam vec_t B_ZLI   = vec_t'(1) << 17;
  localparam vec_t B_ZHI   = vec_t'(1) << 16;
  localparam vec_t B_ZLO   = vec_t'(1) << 15;
  localparam vec_t B_ZHO   = vec_t'(1) << 14;
  localparam vec_t B_HIIN  = vec_t'(1) << 13;
  localparam vec_t B_HIOUT = vec_t'(1) << 12;
  localparam vec_t B_LOIN  = vec_t'(1) << 11;
  localparam vec_t B_LOOUT = vec_t'(1) << 10;
  localparam vec_t B_GRA   = vec_t'(1) << 9;
  localparam vec_t B_GRB   = vec_t'(1) << 8;
  localparam vec_t B_GRC   = vec_t'(1) << 7;
  localparam vec_t B_RIN   = vec_t'(1) << 6;
  localparam vec_t B_ROUT  = vec_t'(1) << 5;
  localparam vec_t B_BAOUT = vec_t'(1) << 4;
  localparam vec_t B_COUT  = vec_t'(1) << 3;
  localparam vec_t B_CONIN = vec_t'(1) << 2;
  localparam vec_t B_INP   = vec_t'(1) << 1;
  localparam vec_t B_OUTP  = vec_t'(1) << 0;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [31:0] ir = '0;
  logic con = 1'b0;
  logic stop = 1'b0;
  logic step = 1'b1;
  logic run, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read, ramWE;
  logic Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, HIout, LOin, LOout;
  logic Gra, Grb, Grc, R_in, R_out, BAout, Cout, CONin, InPortout, OutPortIn;

  int nvec = 0;
  int nmis = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT(MW)) dut (
    .clk(clk), .clr(clr), .ir(ir), .con(con), .stop(stop),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .run(run), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
    .ramWE(ramWE), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin), .HIout(HIout),
    .LOin(LOin), .LOout(LOout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .R_in(R_in), .R_out(R_out), .BAout(BAout), .Cout(Cout),
    .CONin(CONin), .InPortout(InPortout), .OutPortIn(OutPortIn)
  );

  function automatic vec_t pack();
    return {run, PCout, PCin, IncPC, IRin, MARin, MDRin, MDRout, Read,
            ramWE, Yin, ZLowIn, ZHighIn, ZLowout, ZHighout, HIin, HIout,
            LOin, LOout, Gra, Grb, Grc, R_in, R_out, BAout, Cout, CONin,
            InPortout, OutPortIn};
  endfunction

  task automatic cmp(input vec_t got, input vec_t want, input string tag);
    nvec++;
    if (got !== want) begin
      nmis++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(pack(), e.v, e.tag);
    end
  end

  task automatic ex(input vec_t v, input string tag);
    exp_t e;
    e.v = v | B_RUN;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic ex0(input string tag);
    exp_t e;
    e.v = '0;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic push_fetch();
    ex(B_PCOUT | B_MARIN | B_INCPC, "T0");
    for (int i = 0; i <= MW; i++) ex(B_READ | B_MDRIN, "T1");
    ex(B_MDROUT | B_IRIN, "T2");
  endtask

  task automatic push_end();
`ifdef SINGLE_STEP_EN
    ex('0, "pause");
`endif
    ex(B_PCOUT | B_MARIN | B_INCPC, "T0_next");
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
      q.delete();
    end
  endtask

  task automatic begin_scn(input logic [31:0] irv, input logic conv);
    @(posedge clk);
    #1;
    clr = 1'b0;
    ir = irv;
    con = conv;
    stop = 1'b0;
    ex0("rst");
    @(posedge clk);
    #1;
    clr = 1'b1;
    ex0("rst_rel");
  endtask

  task automatic alu_exec(input vec_t t4);
    ex(B_GRB | B_ROUT | B_YIN, "T3");
    ex(t4, "T4");
    ex(B_ZLO | B_GRA | B_RIN, "T5");
  endtask

  initial begin
    // add R1,R2,R4
    begin_scn(32'h1892_0000, 1'b0);
    push_fetch();
    alu_exec(B_GRC | B_ROUT | B_ZLI);
    push_end();
    drain();

    // async reset in the middle of T4
    begin_scn(32'h1892_0000, 1'b0);
    push_fetch();
    ex(B_GRB | B_ROUT | B_YIN, "T3");
    ex(B_GRC | B_ROUT | B_ZLI, "T4");
    drain();
    #2;
    clr = 1'b0;
    #1;
    cmp(pack(), '0, "rst_midT4");
    @(posedge clk);
    #1;
    clr = 1'b1;
    ex0("rst_rel2");
    ex(B_PCOUT | B_MARIN | B_INCPC, "T0_after_rst");
    drain();

    // addi
    begin_scn(32'h6000_0000, 1'b0);
    push_fetch();
    alu_exec(B_COUT | B_ZLI);
    push_end();
    drain();

    // ld with wait states in T1 and T6
    begin_scn(32'h0000_0000, 1'b0);
    push_fetch();
    ex(B_GRB | B_BAOUT | B_ROUT | B_YIN, "ld_T3");
    ex(B_COUT | B_ZLI, "ld_T4");
    ex(B_ZLO | B_MARIN, "ld_T5");
    for (int i = 0; i <= MW; i++) ex(B_READ | B_MDRIN, "ld_T6");
    ex(B_MDROUT | B_GRA | B_RIN, "ld_T7");
    push_end();
    drain();

    // st
    begin_scn(32'h1000_0000, 1'b0);
    push_fetch();
    ex(B_GRB | B_BAOUT | B_ROUT | B_YIN, "st_T3");
    ex(B_COUT | B_ZLI, "st_T4");
    ex(B_ZLO | B_MARIN, "st_T5");
    ex(B_GRA | B_ROUT | B_MDRIN, "st_T6");
    ex(B_RAMWE, "st_T7");
    push_end();
    drain();

    // br not taken, then taken
    for (int c = 0; c < 2; c++) begin
      begin_scn(32'h9800_0000, c[0]);
      push_fetch();
      ex(B_GRA | B_ROUT | B_CONIN, "br_T3");
      ex(B_PCOUT | B_YIN, "br_T4");
      ex(B_COUT | B_ZLI, "br_T5");
      ex(c[0] ? (B_ZLO | B_PCIN) : vec_t'(0), "br_T6");
      push_end();
      drain();
    end

    // mul
    begin_scn(32'h8000_0000, 1'b0);
    push_fetch();
    ex(B_GRA | B_ROUT | B_YIN, "mul_T3");
    ex(B_GRB | B_ROUT | B_ZLI | B_ZHI, "mul_T4");
    ex(B_ZLO | B_LOIN, "mul_T5");
    ex(B_ZHO | B_HIIN, "mul_T6");
    push_end();
    drain();

    // neg, jal, jr, mfhi, out
    begin_scn(32'h8800_0000, 1'b0);
    push_fetch();
    ex(B_GRB | B_ROUT | B_ZLI, "neg_T3");
    ex(B_ZLO | B_GRA | B_RIN, "neg_T4");
    push_end();
    drain();

    begin_scn(32'hA800_0000, 1'b0);
    push_fetch();
    ex(B_PCOUT | B_GRB | B_RIN, "jal_T3");
    ex(B_GRA | B_ROUT | B_PCIN, "jal_T4");
    push_end();
    drain();

    begin_scn(32'hA000_0000, 1'b0);
    push_fetch();
    ex(B_GRA | B_ROUT | B_PCIN, "jr_T3");
    push_end();
    drain();

    begin_scn(32'hC000_0000, 1'b0);
    push_fetch();
    ex(B_HIOUT | B_GRA | B_RIN, "mfhi_T3");
    push_end();
    drain();

    begin_scn(32'hB800_0000, 1'b0);
    push_fetch();
    ex(B_GRA | B_ROUT | B_OUTP, "out_T3");
    push_end();
    drain();

    // nop and an undefined opcode end right after T2
    begin_scn(32'hD000_0000, 1'b0);
    push_fetch();
    push_end();
    drain();

    begin_scn(32'hF800_0000, 1'b0);
    push_fetch();
    push_end();
    drain();

    // halt opcode, stop held in HALT
    begin_scn(32'hD800_0000, 1'b0);
    push_fetch();
    for (int i = 0; i < 20; i++) ex0("halt");
    drain();
    stop = 1'b1;
    for (int i = 0; i < 3; i++) ex0("halt_stop_held");
    drain();

    // stop pulse during fetch of add -> HALT after T5
    begin_scn(32'h1892_0000, 1'b0);
    push_fetch();
    alu_exec(B_GRC | B_ROUT | B_ZLI);
    for (int i = 0; i < 4; i++) ex0("stop_halt");
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    drain();

`ifdef SINGLE_STEP_EN
    // two nops, step low for 10 cycles holds PAUSE
    step = 1'b0;
    begin_scn(32'hD000_0000, 1'b0);
    push_fetch();
    for (int i = 0; i < 10; i++) ex('0, "ss_pause");
    drain();
    step = 1'b1;
    ex(B_PCOUT | B_MARIN | B_INCPC, "ss_T0");
    ex(B_READ | B_MDRIN, "ss_T1");
    @(posedge clk);
    #1;
    step = 1'b0;
    drain();
    step = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
